// File: rtl/vproc_div_iter.sv
// Iterative SIMD integer divider: radix-2 restoring division on 8/16/32-bit lanes,
// BITS_PER_CYCLE quotient bits per lane per cycle, valid/ready in and out.
module vproc_div_iter #(
   parameter int unsigned DIV_OP_W       = 64,
   parameter int unsigned BITS_PER_CYCLE = 1,
   parameter type         CTRL_T         = logic
) (
   input  logic                  clk_i,
   input  logic                  async_rst_ni,
   input  logic                  sync_rst_ni,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  CTRL_T                 in_ctrl_i,
   input  logic [1:0]            in_eew_i,
   input  logic                  in_signed_i,
   input  logic                  in_rem_i,
   input  logic [DIV_OP_W-1:0]   in_op1_i,
   input  logic [DIV_OP_W-1:0]   in_op2_i,
   input  logic [DIV_OP_W/8-1:0] in_mask_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output CTRL_T                 out_ctrl_o,
   output logic [DIV_OP_W-1:0]   out_res_o,
   output logic [DIV_OP_W/8-1:0] out_mask_o,
   output logic                  busy_o
);

   localparam int unsigned MASK_W = DIV_OP_W / 8;
   typedef logic [DIV_OP_W-1:0] vec_t;
   typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

   function automatic logic [31:0] wmask(input int unsigned w);
      return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
   endfunction

   function automatic logic [31:0] msb_bit(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

   function automatic logic is_start(input int unsigned b, input int unsigned w);
      return ((b * 8) % w) == 0;
   endfunction

   function automatic logic [31:0] lane_get(input vec_t v, input int unsigned off, input int unsigned w);
      return 32'(v >> off) & wmask(w);
   endfunction

   function automatic vec_t lane_put(input logic [31:0] x, input int unsigned off);
      return vec_t'(x) << off;
   endfunction

   // One restoring step; rem[31] stands in for the 33rd bit of the shifted remainder.
   function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                            input logic [31:0] dv, input int unsigned w);
      logic [31:0] shifted;
      logic        qb;
      shifted = {rem[30:0], |(quo & msb_bit(w))};
      qb      = rem[31] | (shifted >= dv);
      return {(qb ? shifted - dv : shifted), ((quo << 1) | {31'b0, qb}) & wmask(w)};
   endfunction

   state_t              state_q;
   logic [5:0]          cnt_q;
   CTRL_T               ctrl_q;
   logic [1:0]          eew_q;
   logic                sgn_q, rem_q;
   vec_t                a_q, b_q, r_q;
   logic [MASK_W-1:0]   mask_q, qneg_q, rneg_q;

   int unsigned         sew;
   logic                accept, last_iter;
   vec_t                prep_a, prep_b, calc_a, calc_r, res;
   logic [MASK_W-1:0]   act_c, prep_qneg, prep_rneg;

   always_comb begin
      case (eew_q)
         2'd0:    sew = 8;
         2'd1:    sew = 16;
         default: sew = 32;
      endcase
   end

   assign in_ready_o  = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
   assign accept      = in_valid_i & in_ready_o;
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign last_iter   = (cnt_q == 6'(sew / BITS_PER_CYCLE - 1));
   assign out_res_o   = res;
   assign out_ctrl_o  = ctrl_q;
   assign out_mask_o  = mask_q;

   always_comb begin
      logic [31:0] la, lb;
      logic        sa, sb;
      la = '0; lb = '0; sa = 1'b0; sb = 1'b0;
      prep_a = '0; prep_b = '0; prep_qneg = '0; prep_rneg = '0; act_c = '0;
      for (int unsigned b = 0; b < MASK_W; b++) begin
         act_c[b] = mask_q[b] & is_start(b, sew);
         if (is_start(b, sew)) begin
            la = lane_get(a_q, b * 8, sew);
            lb = lane_get(b_q, b * 8, sew);
            sa = sgn_q & |(la & msb_bit(sew));
            sb = sgn_q & |(lb & msb_bit(sew));
            prep_a |= lane_put(sa ? ((-la) & wmask(sew)) : la, b * 8);
            prep_b |= lane_put(sb ? ((-lb) & wmask(sew)) : lb, b * 8);
            // A zero divisor keeps the all-ones quotient regardless of dividend sign.
            prep_qneg[b] = (sa ^ sb) & (lb != '0);
            prep_rneg[b] = sa;
         end
      end
   end

   always_comb begin
      logic [31:0] lr, lq, ld;
      logic [63:0] st;
      lr = '0; lq = '0; ld = '0; st = '0;
      calc_a = '0; calc_r = '0;
      for (int unsigned b = 0; b < MASK_W; b++) begin
         if (is_start(b, sew)) begin
            lr = lane_get(r_q, b * 8, sew);
            lq = lane_get(a_q, b * 8, sew);
            ld = lane_get(b_q, b * 8, sew);
            for (int unsigned s = 0; s < BITS_PER_CYCLE; s++) begin
               st = div_step(lr, lq, ld, sew);
               lr = st[63:32];
               lq = st[31:0];
            end
            calc_a |= lane_put(lq, b * 8);
            calc_r |= lane_put(lr, b * 8);
         end
      end
   end

   always_comb begin
      logic [31:0] lr, lq, v;
      lr = '0; lq = '0; v = '0;
      res = '0;
      for (int unsigned b = 0; b < MASK_W; b++) begin
         if (act_c[b]) begin
            lq = lane_get(a_q, b * 8, sew);
            lr = lane_get(r_q, b * 8, sew);
            if (rem_q) v = rneg_q[b] ? -lr : lr;
            else       v = qneg_q[b] ? -lq : lq;
            res |= lane_put(v & wmask(sew), b * 8);
         end
      end
   end

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else if (!sync_rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (accept) state_q <= PREP;
            PREP: begin
               cnt_q   <= '0;
               state_q <= (|act_c) ? CALC : DONE;
            end
            CALC: begin
               cnt_q <= cnt_q + 6'd1;
               if (last_iter) state_q <= DONE;
            end
            DONE: if (out_ready_i) state_q <= in_valid_i ? PREP : IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         ctrl_q <= in_ctrl_i;
         eew_q  <= in_eew_i;
         sgn_q  <= in_signed_i;
         rem_q  <= in_rem_i;
         a_q    <= in_op1_i;
         b_q    <= in_op2_i;
         mask_q <= in_mask_i;
      end else if (state_q == PREP) begin
         a_q    <= prep_a;
         b_q    <= prep_b;
         r_q    <= '0;
         qneg_q <= prep_qneg;
         rneg_q <= prep_rneg;
      end else if (state_q == CALC) begin
         a_q <= calc_a;
         r_q <= calc_r;
      end
   end

endmodule

// File: tb/tb_vproc_div_iter.sv
// Scoreboard bench for vproc_div_iter: directed vectors, decoupled driver and monitor.
module tb_vproc_div_iter;

   typedef logic [7:0] ctrl_t;

   logic        clk = 1'b0;
   logic        async_rst_ni, sync_rst_ni;
   logic        in_valid_i, in_ready_o, in_signed_i, in_rem_i;
   ctrl_t       in_ctrl_i, out_ctrl_o;
   logic [1:0]  in_eew_i;
   logic [63:0] in_op1_i, in_op2_i, out_res_o;
   logic [7:0]  in_mask_i, out_mask_o;
   logic        out_valid_o, out_ready_i, busy_o;

   always #5 clk = ~clk;

   vproc_div_iter #(.DIV_OP_W(64), .BITS_PER_CYCLE(1), .CTRL_T(ctrl_t)) dut (
      .clk_i(clk), .async_rst_ni(async_rst_ni), .sync_rst_ni(sync_rst_ni),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_ctrl_i(in_ctrl_i),
      .in_eew_i(in_eew_i), .in_signed_i(in_signed_i), .in_rem_i(in_rem_i),
      .in_op1_i(in_op1_i), .in_op2_i(in_op2_i), .in_mask_i(in_mask_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_ctrl_o(out_ctrl_o),
      .out_res_o(out_res_o), .out_mask_o(out_mask_o), .busy_o(busy_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [63:0] res;
      logic [7:0]  mask;
      ctrl_t       ctrl;
      int          lat;
      int          acc;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: samples 3 time units after the falling edge, well away from the rising edge.
   logic        held = 1'b0;
   logic [63:0] h_res;
   logic [7:0]  h_mask;
   ctrl_t       h_ctrl;
   exp_t        m_e;
   always @(negedge clk) begin
      #3;
      if (out_valid_o) begin
         if (!held) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output: got result %h with no request pending", out_res_o);
            end else begin
               check("latency", 64'(cyc - exp_q[0].acc + 1), 64'(exp_q[0].lat));
            end
            h_res = out_res_o; h_mask = out_mask_o; h_ctrl = out_ctrl_o;
         end else begin
            check("hold_res", out_res_o, h_res);
            check("hold_mask", 64'(out_mask_o), 64'(h_mask));
            check("hold_ctrl", 64'(out_ctrl_o), 64'(h_ctrl));
         end
         if (out_ready_i) begin
            if (exp_q.size() > 0) begin
               m_e = exp_q.pop_front();
               check("result", out_res_o, m_e.res);
               check("out_mask", 64'(out_mask_o), 64'(m_e.mask));
               check("out_ctrl", 64'(out_ctrl_o), 64'(m_e.ctrl));
            end
            held = 1'b0;
         end else begin
            held = 1'b1;
         end
      end else begin
         held = 1'b0;
      end
   end

   // Called right after a falling edge; returns just after the accepting rising edge.
   task automatic send(input logic [1:0] eew, input logic sgn, input logic rem,
                       input logic [63:0] a, input logic [63:0] b, input logic [7:0] m,
                       input ctrl_t c, input logic [63:0] r, input int lat, input bit push);
      int   n;
      exp_t e;
      in_valid_i = 1'b1; in_eew_i = eew; in_signed_i = sgn; in_rem_i = rem;
      in_op1_i = a; in_op2_i = b; in_mask_i = m; in_ctrl_i = c;
      n = 0;
      #1;
      while (!in_ready_o && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (!in_ready_o) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready_o still %b after %0d cycles, required 1", in_ready_o, n);
         in_valid_i = 1'b0;
         return;
      end
      if (push) begin
         e.res = r; e.mask = m; e.ctrl = c; e.lat = lat; e.acc = cyc + 1;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      in_op1_i = {$urandom, $urandom}; in_op2_i = {$urandom, $urandom};
      in_mask_i = 8'($urandom); in_ctrl_i = 8'($urandom);
      in_eew_i = 2'($urandom); in_signed_i = 1'($urandom); in_rem_i = 1'($urandom);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy_o) && n < 300) begin
         @(negedge clk); #4; n++;
      end
      if (exp_q.size() != 0 || busy_o) begin
         checks++; errors++;
         $display("FAIL drain_timeout: %0d results pending, busy_o=%b, required 0 and 0", exp_q.size(), busy_o);
      end
   endtask

   initial begin
      int n;
      async_rst_ni = 1'b0; sync_rst_ni = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
      in_ctrl_i = '0; in_eew_i = '0; in_signed_i = 1'b0; in_rem_i = 1'b0;
      in_op1_i = '0; in_op2_i = '0; in_mask_i = '0;
      #2;
      check("rst_valid", 64'(out_valid_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_ready", 64'(in_ready_o), 64'd1);
      @(negedge clk); @(negedge clk);
      async_rst_ni = 1'b1;

      // Unsigned SEW=8, 200/7 in every lane
      @(negedge clk);
      send(2'd0, 1'b0, 1'b0, 64'hC8C8C8C8C8C8C8C8, 64'h0707070707070707, 8'hFF, 8'hA1,
           64'h1C1C1C1C1C1C1C1C, 10, 1);
      // Signed SEW=8 mix: negatives, overflow, divide by zero; remainder then quotient
      @(negedge clk);
      send(2'd0, 1'b1, 1'b1, 64'h7FFF059C648007F9, 64'h8005030700FFFE02, 8'hFF, 8'hB2,
           64'h7FFF02FE640001FF, 10, 1);
      @(negedge clk);
      send(2'd0, 1'b1, 1'b0, 64'h7FFF059C648007F9, 64'h8005030700FFFE02, 8'hFF, 8'hB3,
           64'h000001F2FF80FDFD, 10, 1);
      // SEW=16 divide by zero
      @(negedge clk);
      send(2'd1, 1'b0, 1'b0, 64'h0000FFFF80011234, 64'h0, 8'hFF, 8'hC4,
           64'hFFFFFFFFFFFFFFFF, 18, 1);
      @(negedge clk);
      send(2'd1, 1'b0, 1'b1, 64'h0000FFFF80011234, 64'h0, 8'hFF, 8'hC5,
           64'h0000FFFF80011234, 18, 1);
      @(negedge clk);
      send(2'd1, 1'b1, 1'b1, 64'h0000FFFF80011234, 64'h0, 8'hFF, 8'hC6,
           64'h0000FFFF80011234, 18, 1);
      @(negedge clk);
      send(2'd1, 1'b1, 1'b0, 64'h0000FFFF80011234, 64'h0, 8'hFF, 8'hC7,
           64'hFFFFFFFFFFFFFFFF, 18, 1);
      // SEW=16 partial mask: only lanes whose lowest byte is enabled produce results
      @(negedge clk);
      send(2'd1, 1'b0, 1'b0, 64'h006403E8FFFF0010, 64'h0003000700010004, 8'h52, 8'hD8,
           64'h0021008E00000000, 18, 1);
      // All lanes masked off: early-out
      @(negedge clk);
      send(2'd2, 1'b1, 1'b0, 64'h123456789ABCDEF0, 64'h1111111122222222, 8'h00, 8'hE9,
           64'h0, 2, 1);
      wait_drain();

      // Signed SEW=32 with output held, then back-to-back accept on the drain edge
      @(negedge clk);
      out_ready_i = 1'b0;
      send(2'd2, 1'b1, 1'b1, 64'h80000000FFFFFFF9, 64'hFFFFFFFF00000002, 8'hFF, 8'h3A,
           64'h00000000FFFFFFFF, 34, 1);
      n = 0;
      while (!out_valid_o && n < 100) begin
         @(negedge clk); #1; n++;
      end
      check("held_reached_done", 64'(out_valid_o), 64'd1);
      repeat (5) begin
         @(negedge clk); #1;
         check("held_in_ready", 64'(in_ready_o), 64'd0);
         check("held_out_valid", 64'(out_valid_o), 64'd1);
      end
      @(negedge clk);
      out_ready_i = 1'b1;
      send(2'd2, 1'b1, 1'b0, 64'h80000000FFFFFFF9, 64'hFFFFFFFF00000002, 8'hFF, 8'h3B,
           64'h80000000FFFFFFFD, 34, 1);
      check("b2b_busy", 64'(busy_o), 64'd1);
      check("b2b_valid_low", 64'(out_valid_o), 64'd0);
      wait_drain();

      // Synchronous reset mid-CALC discards the operation
      @(negedge clk);
      send(2'd0, 1'b0, 1'b0, 64'hC8C8C8C8C8C8C8C8, 64'h0707070707070707, 8'hFF, 8'h77,
           64'h0, 0, 0);
      repeat (5) @(negedge clk);
      sync_rst_ni = 1'b0;
      @(posedge clk); #1;
      check("srst_busy", 64'(busy_o), 64'd0);
      check("srst_ready", 64'(in_ready_o), 64'd1);
      check("srst_valid", 64'(out_valid_o), 64'd0);
      @(negedge clk);
      sync_rst_ni = 1'b1;
      repeat (40) @(negedge clk);
      send(2'd0, 1'b0, 1'b0, 64'hC8C8C8C8C8C8C8C8, 64'h0707070707070707, 8'h0F, 8'h5A,
           64'h000000001C1C1C1C, 10, 1);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vproc_div_iter.md
VPROC_DIV_ITER -- requirements
Module: vproc_div_iter

Interface
REQ-001 SHALL have parameter DIV_OP_W, default 64: datapath width in bits; multiple of 32, at least 32.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: quotient bits retired per lane per CALC cycle; legal values 1, 2, 4, 8.
REQ-003 SHALL have parameter CTRL_T, default logic: opaque control word passed through unchanged.
REQ-004 SHALL have ports, clock and reset first:
- clk_i  in  1  clock.
- async_rst_ni  in  1  reset, asynchronous, active-low.
- sync_rst_ni  in  1  synchronous reset, active-low.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when high together with in_valid_i.
- in_ctrl_i  in  CTRL_T  pass-through control.
- in_eew_i  in  2  element width: 0=8, 1=16, 2=32 bits; 3 illegal.
- in_signed_i  in  1  signed division.
- in_rem_i  in  1  1=remainder, 0=quotient.
- in_op1_i  in  DIV_OP_W  dividend vector.
- in_op2_i  in  DIV_OP_W  divisor vector.
- in_mask_i  in  DIV_OP_W/8  byte enable mask.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result consumed.
- out_ctrl_o  out  CTRL_T  registered in_ctrl_i.
- out_res_o  out  DIV_OP_W  result vector.
- out_mask_o  out  DIV_OP_W/8  registered in_mask_i.
- busy_o  out  1  FSM not IDLE.

Function
REQ-005 SHALL operate on DIV_OP_W/SEW independent lanes in parallel, where SEW is the width selected by in_eew_i.
REQ-006 SHALL implement FSM states IDLE, PREP, CALC and DONE.
REQ-007 SHALL take the following transitions:
- IDLE->PREP on handshake.
- PREP->CALC, iteration counter cleared.
- CALC->DONE after SEW/BITS_PER_CYCLE iterations.
- DONE->IDLE on out_ready_i.
- DONE->PREP on out_ready_i and in_valid_i together.
REQ-008 SHALL register all in_* operands and control on the handshake edge; inputs are ignored at all other times.
REQ-009 PREP SHALL form per-lane absolute values of dividend and divisor (sign taken from the SEW MSB when in_signed_i=1) and record the quotient and remainder signs.
REQ-010 CALC SHALL run radix-2 restoring division, BITS_PER_CYCLE steps per cycle, on SEW-bit magnitudes.
REQ-011 DONE SHALL apply signs: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-012 Latency SHALL be exactly SEW/BITS_PER_CYCLE+2 clock edges from the accept edge to out_valid_o high. Example: SEW=32, BITS_PER_CYCLE=1 gives 34.
REQ-013 Early-out: when every lane is masked off, PREP SHALL go directly to DONE, giving latency 2.
REQ-014 A lane SHALL be active iff in_mask_i bit at the lane's lowest byte is 1.
REQ-015 Inactive lanes SHALL return 0 in out_res_o.
REQ-016 Divisor zero SHALL give quotient all-ones and remainder equal to the dividend, in both signed and unsigned mode.
REQ-017 Signed overflow (dividend = most negative value, divisor = -1) SHALL give quotient equal to the dividend and remainder 0.
REQ-018 in_ready_o SHALL be high in IDLE, and in DONE while out_ready_i is high; it SHALL be low in PREP and CALC.
REQ-019 out_valid_o SHALL be high only in DONE.
REQ-020 out_res_o, out_ctrl_o and out_mask_o SHALL stay stable while out_valid_o is high and out_ready_i is low.
REQ-021 Back-to-back: a new request accepted on the same edge that DONE is drained SHALL start PREP with no idle cycle.
REQ-022 in_eew_i=3 SHALL be treated as SEW=32; the result is don't-care.

Reset
REQ-023 async_rst_ni low SHALL immediately force IDLE, with out_valid_o=0, busy_o=0 and in_ready_o=1.
REQ-024 sync_rst_ni low at a clock edge SHALL have the same effect as REQ-023, including mid-CALC; the in-flight operation is discarded and no result is emitted.
REQ-025 Datapath registers SHALL need no reset; out_res_o is don't-care while out_valid_o=0.

Verification
REQ-026 Unsigned SEW=8, BITS_PER_CYCLE=1, all lanes 200/7, in_rem_i=0 -> every byte 0x1C; out_valid_o 10 edges after accept.
REQ-027 Signed SEW=32, DIV_OP_W=64:
- lane0 -7/2 with in_rem_i=1 -> 0xFFFFFFFF (remainder -1).
- lane1 0x80000000/0xFFFFFFFF with in_rem_i=0 -> 0x80000000 (overflow rule).
REQ-028 SEW=16 divide by zero, dividend 0x1234: quotient 0xFFFF; with in_rem_i=1, result 0x1234.
REQ-029 in_mask_i all zeros -> out_valid_o 2 edges after accept, out_res_o=0, out_mask_o=0.
REQ-030 Hold out_ready_i low for 5 cycles in DONE -> outputs stable and in_ready_o low; then out_ready_i and in_valid_i high together -> next op accepted on that edge and busy_o stays high.
REQ-031 Pulse sync_rst_ni low during CALC -> IDLE next edge, out_valid_o never asserts for that op, next request completes correctly.
